// File: rtl/debug_dump_ctrl.sv
// debug_dump_ctrl: walks the core's debug read ports (register file, then a
// data-memory window) and streams each captured word out as a tagged
// valid/ready beat.
module debug_dump_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     NUM_RF    = 32,
  parameter logic [XLEN-1:0] DF_BASE   = '0,
  parameter int unsigned     DF_WORDS  = 16,
  parameter int unsigned     DF_STRIDE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [4:0]      debug_addr_RF,
  input  logic [XLEN-1:0] debug_data_RF,
  output logic [XLEN-1:0] debug_addr_DF,
  input  logic [XLEN-1:0] debug_data_DF,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_src,
  output logic [XLEN-1:0] out_idx,
  output logic [XLEN-1:0] out_data,
  output logic            busy,
  output logic            done
);

  // Counter widths cover NUM_RF-1 and DF_WORDS-1; at least one bit each.
  localparam int unsigned     RF_IW   = (NUM_RF > 1) ? $clog2(NUM_RF) : 1;
  localparam int unsigned     DF_KW   = (DF_WORDS > 1) ? $clog2(DF_WORDS) : 1;
  localparam logic [RF_IW-1:0] RF_LAST = RF_IW'(NUM_RF - 1);
  localparam logic [DF_KW-1:0] DF_LAST = DF_KW'((DF_WORDS > 0) ? DF_WORDS - 1 : 0);
  localparam logic [XLEN-1:0]  DF_STEP = XLEN'(DF_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RF_ADDR = 3'd1,
    S_RF_OUT  = 3'd2,
    S_DF_ADDR = 3'd3,
    S_DF_OUT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  logic [RF_IW-1:0] r_i;
  logic [DF_KW-1:0] r_k;
  logic [4:0]       r_addr_rf;
  logic [XLEN-1:0]  r_addr_df;
  logic             r_valid;
  logic             r_src;
  logic [XLEN-1:0]  r_idx;
  logic [XLEN-1:0]  r_data;
  logic             r_busy;
  logic             r_done;

  // Dump sequencer: the debug addresses are registered alongside the index
  // counters so the core's combinational read is settled by the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_k       <= '0;
      r_addr_rf <= '0;
      r_addr_df <= '0;
      r_valid   <= 1'b0;
      r_src     <= 1'b0;
      r_idx     <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state   <= S_RF_ADDR;
            r_i       <= '0;
            r_addr_rf <= '0;
            r_busy    <= 1'b1;
          end
        end

        S_RF_ADDR: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_data  <= debug_data_RF;
            r_idx   <= XLEN'(r_i);
            r_src   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_RF_OUT;
          end
        end

        S_RF_OUT: begin
          // abort wins over a simultaneous handshake; the beat was still taken
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (out_ready) begin
            r_valid <= 1'b0;
            if (r_i == RF_LAST) begin
              if (DF_WORDS == 0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= S_DF_ADDR;
                r_k       <= '0;
                r_addr_df <= DF_BASE;
              end
            end else begin
              r_i       <= r_i + 1'b1;
              r_addr_rf <= 5'(r_i + 1'b1);
              r_state   <= S_RF_ADDR;
            end
          end
        end

        S_DF_ADDR: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_data  <= debug_data_DF;
            r_idx   <= r_addr_df;
            r_src   <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DF_OUT;
          end
        end

        S_DF_OUT: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (out_ready) begin
            r_valid <= 1'b0;
            if (r_k == DF_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_k       <= r_k + 1'b1;
              // address wraps modulo 2^XLEN by plain truncation
              r_addr_df <= r_addr_df + DF_STEP;
              r_state   <= S_DF_ADDR;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign debug_addr_RF = r_addr_rf;
  assign debug_addr_DF = r_addr_df;
  assign out_valid     = r_valid;
  assign out_src       = r_src;
  assign out_idx       = r_idx;
  assign out_data      = r_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Bench for debug_dump_ctrl: three instances (default window, no memory
// window, wrapping memory window) share start/abort/rst and a modelled core;
// a beat-level reference model predicts every output on every cycle.
module tb_debug_dump_ctrl;

  localparam int NCFG = 3;
  localparam int NRF  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        abort;
  logic        ready   [NCFG];
  logic [4:0]  addr_rf [NCFG];
  logic [31:0] data_rf [NCFG];
  logic [31:0] addr_df [NCFG];
  logic [31:0] data_df [NCFG];
  logic        o_valid [NCFG];
  logic        o_src   [NCFG];
  logic [31:0] o_idx   [NCFG];
  logic [31:0] o_data  [NCFG];
  logic        o_busy  [NCFG];
  logic        o_done  [NCFG];

  logic [31:0] rf_mem [NRF];
  logic [31:0] df_xor;
  logic [31:0] lit_wrap [4];

  function automatic int cfg_words(int g);
    return (g == 0) ? 16 : (g == 1) ? 0 : 4;
  endfunction

  function automatic logic [31:0] cfg_base(int g);
    return (g == 2) ? 32'hFFFF_FFF8 : 32'h0;
  endfunction

  // core data memory: DF[a] = 0xA000 + a/4, optionally scrambled
  function automatic logic [31:0] df_val(logic [31:0] a, logic [31:0] x);
    return (32'hA000 + (a >> 2)) ^ x;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_dut
      assign data_rf[gi] = rf_mem[addr_rf[gi]];
      assign data_df[gi] = df_val(addr_df[gi], df_xor);
      debug_dump_ctrl #(
        .XLEN(32), .NUM_RF(NRF),
        .DF_BASE((gi == 2) ? 32'hFFFF_FFF8 : 32'h0),
        .DF_WORDS((gi == 0) ? 16 : (gi == 1) ? 0 : 4),
        .DF_STRIDE(4)
      ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .debug_addr_RF(addr_rf[gi]), .debug_data_RF(data_rf[gi]),
        .debug_addr_DF(addr_df[gi]), .debug_data_DF(data_df[gi]),
        .out_valid(o_valid[gi]), .out_ready(ready[gi]), .out_src(o_src[gi]),
        .out_idx(o_idx[gi]), .out_data(o_data[gi]),
        .busy(o_busy[gi]), .done(o_done[gi])
      );
    end
  endgenerate

  // ---------------- reference model (beat list + offer/gap phases) ----------
  function automatic logic [31:0] beat_idx(int g, int b);
    if (b < NRF) return 32'(b);
    return cfg_base(g) + 32'(b - NRF) * 32'd4;
  endfunction

  function automatic logic [31:0] beat_data(int g, int b);
    if (b < NRF) return rf_mem[b];
    return df_val(beat_idx(g, b), df_xor);
  endfunction

  typedef enum int {PH_IDLE, PH_ADDR, PH_OFFER, PH_DONE} ph_t;
  ph_t         m_ph    [NCFG];
  int          m_beat  [NCFG];
  bit          m_valid [NCFG];
  bit          m_busy  [NCFG];
  bit          m_done  [NCFG];
  bit          m_src   [NCFG];
  logic [31:0] m_idx   [NCFG];
  logic [31:0] m_data  [NCFG];
  logic [4:0]  m_rfa   [NCFG];
  logic [31:0] m_dfa   [NCFG];

  always @(posedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      if (rst) begin
        m_ph[g] = PH_IDLE; m_beat[g] = 0; m_valid[g] = 0; m_busy[g] = 0;
        m_done[g] = 0; m_src[g] = 0; m_idx[g] = '0; m_data[g] = '0;
        m_rfa[g] = '0; m_dfa[g] = '0;
      end else begin
        case (m_ph[g])
          PH_IDLE: if (start && !abort) begin
            m_ph[g] = PH_ADDR; m_busy[g] = 1; m_beat[g] = 0; m_rfa[g] = '0;
          end
          PH_ADDR: if (abort) begin
            m_ph[g] = PH_IDLE; m_busy[g] = 0;
          end else begin
            m_ph[g]    = PH_OFFER;
            m_valid[g] = 1;
            m_src[g]   = (m_beat[g] >= NRF);
            m_idx[g]   = beat_idx(g, m_beat[g]);
            m_data[g]  = beat_data(g, m_beat[g]);
          end
          PH_OFFER: if (abort) begin
            m_ph[g] = PH_IDLE; m_busy[g] = 0; m_valid[g] = 0;
          end else if (ready[g]) begin
            m_valid[g] = 0;
            m_beat[g]  = m_beat[g] + 1;
            if (m_beat[g] == NRF + cfg_words(g)) begin
              m_ph[g] = PH_DONE; m_done[g] = 1;
            end else begin
              m_ph[g] = PH_ADDR;
              if (m_beat[g] < NRF) m_rfa[g] = 5'(m_beat[g]);
              else                 m_dfa[g] = beat_idx(g, m_beat[g]);
            end
          end
          default: begin
            m_ph[g] = PH_IDLE; m_done[g] = 0; m_busy[g] = 0;
          end
        endcase
      end
    end
  end

  // ---------------- compare process ----------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  bit lit_mode = 0;
  bit abort_lit = 0;

  bit          p_valid [NCFG];
  bit          p_busy  [NCFG];
  bit          p_done  [NCFG];
  bit          p_src   [NCFG];
  logic [31:0] p_idx   [NCFG];
  logic [31:0] p_data  [NCFG];
  int          d_cnt   [NCFG];
  int          d_done  [NCFG];
  int          start_cyc [NCFG];
  int          done_cyc  [NCFG];

  task automatic chk(int g, string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, g, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    cyc++;
    chk(0, "wait_timeout", 32'(tmo_req), 32'(tmo_seen));
    tmo_seen = tmo_req;
    for (int g = 0; g < NCFG; g++) begin
      // beat taken at the edge just passed (abort still counts it)
      if (!rst && p_valid[g] && ready[g] === 1'b1) begin
        n = d_cnt[g];
        if (lit_mode && n < NRF) begin
          chk(g, "lit_rf_idx", p_idx[g], 32'(n));
          chk(g, "lit_rf_data", p_data[g], 32'(n * 3));
          chk(g, "lit_rf_src", 32'(p_src[g]), 32'd0);
        end
        if (lit_mode && g == 0 && n >= NRF) begin
          chk(g, "lit_df_idx", p_idx[g], 32'((n - NRF) * 4));
          chk(g, "lit_df_data", p_data[g], 32'hA000 + 32'(n - NRF));
          chk(g, "lit_df_src", 32'(p_src[g]), 32'd1);
        end
        if (g == 2 && n >= NRF && n < NRF + 4)
          chk(g, "lit_wrap_addr", p_idx[g], lit_wrap[n - NRF]);
        d_cnt[g]++;
      end
      // back-pressured beat must be held unchanged
      if (!rst && p_valid[g] && ready[g] === 1'b0 && !abort) begin
        chk(g, "hold_valid", 32'(o_valid[g]), 32'd1);
        chk(g, "hold_data", o_data[g], p_data[g]);
        chk(g, "hold_idx", o_idx[g], p_idx[g]);
      end
      if (rst) begin
        chk(g, "rst_valid", 32'(o_valid[g]), 32'd0);
        chk(g, "rst_busy", 32'(o_busy[g]), 32'd0);
        chk(g, "rst_done", 32'(o_done[g]), 32'd0);
        chk(g, "rst_idx", o_idx[g], 32'd0);
        chk(g, "rst_data", o_data[g], 32'd0);
        chk(g, "rst_addr_rf", 32'(addr_rf[g]), 32'd0);
        chk(g, "rst_addr_df", addr_df[g], 32'd0);
      end
      if (g == 1) chk(g, "nodf_addr_df", addr_df[g], 32'd0);
      // cycle-accurate comparison against the model
      chk(g, "valid", 32'(o_valid[g]), 32'(m_valid[g]));
      chk(g, "busy", 32'(o_busy[g]), 32'(m_busy[g]));
      chk(g, "done", 32'(o_done[g]), 32'(m_done[g]));
      chk(g, "src", 32'(o_src[g]), 32'(m_src[g]));
      chk(g, "idx", o_idx[g], m_idx[g]);
      chk(g, "data", o_data[g], m_data[g]);
      chk(g, "addr_rf", 32'(addr_rf[g]), 32'(m_rfa[g]));
      chk(g, "addr_df", addr_df[g], m_dfa[g]);
      // per-dump bookkeeping
      if (o_done[g] === 1'b1) begin
        d_done[g]++;
        done_cyc[g] = cyc;
      end
      if (!p_busy[g] && o_busy[g] === 1'b1) begin
        d_cnt[g] = 0; d_done[g] = 0; start_cyc[g] = cyc;
      end
      if (p_busy[g] && o_busy[g] === 1'b0 && !rst) begin
        if (p_done[g]) begin
          chk(g, "dump_beats", 32'(d_cnt[g]), 32'(NRF + cfg_words(g)));
          chk(g, "done_pulses", 32'(d_done[g]), 32'd1);
          chk(g, "dump_min_len", 32'(done_cyc[g] - start_cyc[g] >= 2 * (NRF + cfg_words(g))), 32'd1);
        end else begin
          chk(g, "abort_no_done", 32'(d_done[g]), 32'd0);
          if (abort_lit) chk(g, "abort_beats", 32'(d_cnt[g]), 32'd6);
        end
      end
      p_valid[g] = (o_valid[g] === 1'b1);
      p_busy[g]  = (o_busy[g] === 1'b1);
      p_done[g]  = (o_done[g] === 1'b1);
      p_src[g]   = (o_src[g] === 1'b1);
      p_idx[g]   = o_idx[g];
      p_data[g]  = o_data[g];
    end
  end

  // ---------------- out_ready driver ---------------------------------------
  int rdy_mode = 0;
  int rc = 0;
  always begin
    @(negedge clk);
    #1;
    rc++;
    for (int g = 0; g < NCFG; g++) begin
      case (rdy_mode)
        0:       ready[g] = 1'b1;
        1:       ready[g] = (g == 0) ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
        default: ready[g] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int c = 0;
    while ((o_busy[0] || o_busy[1] || o_busy[2]) && c < bound) begin
      tick();
      c++;
    end
    if (c >= bound) tmo_req++;
    tick(2);
  endtask

  task automatic wait_for_beat(bit src, logic [31:0] idx, int bound);
    int c = 0;
    while (!(o_valid[0] && o_src[0] == src && o_idx[0] == idx) && c < bound) begin
      tick();
      c++;
    end
    if (c >= bound) tmo_req++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; df_xor = '0;
    lit_wrap[0] = 32'hFFFF_FFF8; lit_wrap[1] = 32'hFFFF_FFFC;
    lit_wrap[2] = 32'h0000_0000; lit_wrap[3] = 32'h0000_0004;
    for (int n = 0; n < NRF; n++) rf_mem[n] = 32'(n * 3);
    lit_mode = 1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // full dump with the sink always ready
    pulse_start();
    wait_idle(400);

    // back-pressure, plus start pulses that must be ignored while busy
    rdy_mode = 1;
    pulse_start();
    for (int r = 0; r < 30; r++) begin
      tick($urandom_range(1, 8));
      if (o_busy[0]) pulse_start();
    end
    wait_idle(1000);

    // abort on the handshake of register beat 5, then restart from 0
    rdy_mode = 0;
    tick(2);
    pulse_start();
    abort_lit = 1;
    wait_for_beat(1'b0, 32'd5, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(3);
    abort_lit = 0;
    start = 1'b1; abort = 1'b1;   // start with abort in idle: stays idle
    tick();
    start = 1'b0; abort = 1'b0;
    tick(2);
    pulse_start();
    wait_idle(400);

    // reset in the middle of the memory phase
    pulse_start();
    wait_for_beat(1'b1, 32'd8, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    pulse_start();
    wait_idle(400);

    // randomized contents, sink and start/abort traffic
    lit_mode = 0;
    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      for (int n = 0; n < NRF; n++) rf_mem[n] = $urandom;
      df_xor = $urandom;
      pulse_start();
      for (int c = 0; c < 250; c++) begin
        start = ($urandom_range(0, 19) == 0);
        abort = ($urandom_range(0, 59) == 0);
        tick();
      end
      start = 1'b0; abort = 1'b0;
      wait_idle(1000);
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debug_dump_ctrl.md
Name: debug_dump_ctrl

Overview:
Debug-side master for the core's debug read ports. After a start command it drives the register-file debug address over all registers, then the data-memory debug address over a configured window. It captures each returned word and emits it as a valid/ready stream of tagged beats. It sits outside the core, for example in front of a UART or testbench sink, and is the consumer end of debug_addr_RF/debug_data_RF and debug_addr_DF/debug_data_DF.

Parameters:
XLEN, 32, data and data-memory address width
NUM_RF, 32, number of registers dumped (indices 0..NUM_RF-1)
DF_BASE, 0, first data-memory byte address dumped
DF_WORDS, 16, number of data-memory words dumped (0 = skip the memory phase)
DF_STRIDE, 4, byte increment between memory words

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  begin a dump; sampled only in IDLE
abort  in  1  terminate the current dump
debug_addr_RF  out  5  register index to the core
debug_data_RF  in  XLEN  register value from the core (combinational read)
debug_addr_DF  out  XLEN  memory byte address to the core
debug_data_DF  in  XLEN  memory word from the core (combinational read)
out_valid  out  1  beat available
out_ready  in  1  sink accepts beat
out_src  out  1  0 = register file, 1 = data memory
out_idx  out  XLEN  register index (zero-extended) or memory byte address
out_data  out  XLEN  captured value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, all outputs 0, debug_addr_RF=0, debug_addr_DF=0, counters 0. rst mid-dump returns to these values at the next edge; no done pulse.
- States: IDLE, RF_ADDR, RF_OUT, DF_ADDR, DF_OUT, DONE.
- IDLE: if start && !abort, go to RF_ADDR with i=0 and busy=1. start is ignored in every other state.
- RF_ADDR (one cycle): debug_addr_RF=i. At the end of this cycle:
  - capture out_data<=debug_data_RF, out_idx<=i, out_src<=0, out_valid<=1;
  - go to RF_OUT.
- RF_OUT: hold out_valid, out_data, out_idx, out_src and debug_addr_RF stable until out_valid && out_ready. On that handshake, out_valid<=0. Then:
  - if i==NUM_RF-1, go to DF_ADDR with k=0, or to DONE if DF_WORDS==0;
  - otherwise i<=i+1 and go to RF_ADDR.
- DF_ADDR / DF_OUT: same as the RF states, with these differences:
  - debug_addr_DF = DF_BASE + k*DF_STRIDE, truncated to XLEN bits (wraps modulo 2^XLEN);
  - out_src=1 and out_idx is that address;
  - the last beat is k==DF_WORDS-1, after which the FSM goes to DONE.
- DONE (one cycle): done=1, busy=1. Next state IDLE; busy drops the following cycle.
- Throughput: at most one beat per 2 cycles. Exactly NUM_RF+DF_WORDS beats per completed dump, registers first, in ascending order.
- out_ready is ignored when out_valid=0. A beat is never dropped or duplicated under back-pressure.
- abort:
  - while busy, next state is IDLE with out_valid<=0 and no done pulse;
  - abort overrides a handshake in the same cycle; that beat counts as delivered;
  - abort in IDLE has no effect, and abort together with start in IDLE keeps the FSM in IDLE.
- In IDLE, debug_addr_RF and debug_addr_DF hold their last driven values (0 after reset).
- Counters are sized to hold NUM_RF-1 and DF_WORDS-1 without overflow.

Test Plan:
- Reset then start, out_ready=1, core RF[n]=n*3, DF[4k]=0xA000+k, defaults -> 48 beats. Beats 0..31 are (src0, idx n, data n*3); beats 32..47 are (src1, addr 0,4,..,60, data 0xA000..0xA00F). done pulses once, 96+ cycles after start.
- Back-pressure: out_ready toggles 1-of-3 cycles -> same 48-beat sequence with no gaps or repeats. out_data stays stable while valid&&!ready.
- abort asserted during the RF_OUT of index 5 while out_ready=1 -> beat 5 counts as delivered, no beat 6, busy=0 next cycle, done never pulses. A following start restarts at index 0.
- DF_WORDS=0 -> exactly 32 RF beats, then done. debug_addr_DF never leaves 0.
- DF_BASE=0xFFFFFFF8, DF_WORDS=4 -> memory addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst asserted mid-DF phase -> next cycle all outputs 0 and state IDLE. start pulses while busy are ignored, with no restart or reordering.
